// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: bundles the handshake, control and register-file-facing signals of
// regfile_wr_arbiter.
//
// Signals:
//   req0_valid/addr/data, req0_ready : requester 0 write channel (ready driven by arbiter)
//   req1_valid/addr/data, req1_ready : requester 1 write channel (ready driven by arbiter)
//   clear_start                      : single-cycle pulse requesting a zero sweep
//   busy                             : clear sweep in progress
//   rf_write_en/addr, rf_data_in     : register-file write port
//   gnt_cnt0/1                       : per-requester transfer counters (REGFILE_ARB_STATS_EN only)
//
// Modports:
//   master : requester/controller side (drives requests and clear_start)
//   slave  : arbiter side
//
// Optional feature macro: REGFILE_ARB_STATS_EN adds gnt_cnt0/gnt_cnt1.

interface regfile_wr_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic              clear_start;
  logic              busy;

  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_data_in;

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0]       gnt_cnt0;
  logic [15:0]       gnt_cnt1;
`endif

  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output clear_start,
    input  busy, rf_write_en, rf_write_addr, rf_data_in
`ifdef REGFILE_ARB_STATS_EN
    , input gnt_cnt0, gnt_cnt1
`endif
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  clear_start,
    output busy, rf_write_en, rf_write_addr, rf_data_in
`ifdef REGFILE_ARB_STATS_EN
    , output gnt_cnt0, gnt_cnt1
`endif
  );

endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the single write port of a 2^ADDR_W x DATA_W register file between
// two valid/ready requesters using round-robin arbitration, and provides a clear sequencer that
// sweeps every register to zero on command.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus_io : regfile_wr_arbiter_if.slave
//            - reqN_valid/addr/data in, reqN_ready out (combinational)
//            - clear_start in (single-cycle pulse), busy out (registered)
//            - rf_write_en/rf_write_addr/rf_data_in out (registered, 1-cycle latency)
//            - gnt_cnt0/gnt_cnt1 out when REGFILE_ARB_STATS_EN is defined
//
// Optional feature macro: REGFILE_ARB_STATS_EN adds saturating 16-bit per-requester transfer
// counters. They are cleared only by rst_n, never by the clear sweep.
//
// Sweep timing: the edge that samples clear_start drives address 0; each following edge in
// StClear drives the next address. The state stays in StClear while address 2^ADDR_W-1 is on
// the outputs, so busy (== state is StClear) covers exactly the 2^ADDR_W write cycles and no
// request can be accepted until the sweep has fully drained.

module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wr_arbiter_if.slave  bus_io
);

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

  // The counter is one bit wider than the address so it can reach 2^ADDR_W, which marks the
  // cycle after the last address has been driven.
  localparam logic [ADDR_W:0] SweepEnd = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_data_q, rf_data_d;

  logic grant0, grant1;
  logic ready0, ready1;
  logic xfer0, xfer1;
  logic idle;

  assign idle = (state_q == StIdle);

  // Round-robin: on a tie the requester that did not win last time gets the port.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case ({bus_io.req1_valid, bus_io.req0_valid})
      2'b01:   grant0 = 1'b1;
      2'b10:   grant1 = 1'b1;
      2'b11: begin
        grant0 = last_grant_q;
        grant1 = ~last_grant_q;
      end
      default: ;
    endcase
  end

  // clear_start wins over any request presented in the same cycle.
  assign ready0 = grant0 & idle & ~bus_io.clear_start;
  assign ready1 = grant1 & idle & ~bus_io.clear_start;
  assign xfer0  = bus_io.req0_valid & ready0;
  assign xfer1  = bus_io.req1_valid & ready1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    clr_cnt_d    = clr_cnt_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_data_d    = rf_data_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.clear_start) begin
          state_d   = StClear;
          rf_we_d   = 1'b1;
          rf_addr_d = '0;
          rf_data_d = '0;
          clr_cnt_d = CntOne;
        end else if (xfer0) begin
          rf_we_d      = 1'b1;
          rf_addr_d    = bus_io.req0_addr;
          rf_data_d    = bus_io.req0_data;
          last_grant_d = 1'b0;
        end else if (xfer1) begin
          rf_we_d      = 1'b1;
          rf_addr_d    = bus_io.req1_addr;
          rf_data_d    = bus_io.req1_data;
          last_grant_d = 1'b1;
        end
      end
      StClear: begin
        if (clr_cnt_q == SweepEnd) begin
          // Last address is on the outputs now; this edge ends the sweep.
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          rf_we_d   = 1'b1;
          rf_addr_d = clr_cnt_q[ADDR_W-1:0];
          rf_data_d = '0;
          clr_cnt_d = clr_cnt_q + CntOne;
        end
      end
      default: begin
        state_d   = StIdle;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      clr_cnt_q    <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      clr_cnt_q    <= clr_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign bus_io.req0_ready    = ready0;
  assign bus_io.req1_ready    = ready1;
  assign bus_io.busy          = (state_q == StClear);
  assign bus_io.rf_write_en   = rf_we_q;
  assign bus_io.rf_write_addr = rf_addr_q;
  assign bus_io.rf_data_in    = rf_data_q;

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] gnt_cnt0_q;
  logic [15:0] gnt_cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      if (xfer0 && (gnt_cnt0_q != 16'hFFFF)) begin
        gnt_cnt0_q <= gnt_cnt0_q + 16'd1;
      end
      if (xfer1 && (gnt_cnt1_q != 16'hFFFF)) begin
        gnt_cnt1_q <= gnt_cnt1_q + 16'd1;
      end
    end
  end

  assign bus_io.gnt_cnt0 = gnt_cnt0_q;
  assign bus_io.gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule
